// File: rtl/alu_op_ctrl.sv
// Command sequencer for the shared add/sub/mul/div result mux: accepts one
// command, launches the selected unit, and returns the captured result with an error flag.
module alu_op_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [1:0]   sel,
    output logic         mul_start,
    output logic         div_start,
    input  logic         mul_done,
    input  logic         div_done,
    input  logic [W-1:0] mux_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        WAIT    = 2'b10,
        RESULT  = 2'b11
    } state_t;

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  op_a_q;
    logic [W-1:0]  op_b_q;
    logic [1:0]    sel_q;
    logic          mul_start_q;
    logic          div_start_q;
    logic [W-1:0]  res_data_q;
    logic          res_err_q;
    logic          done_sel;

    // Only the unit that was launched may finish the operation.
    always_comb begin
        done_sel = 1'b0;
        if (sel_q == OP_MUL) begin
            done_sel = mul_done;
        end else if (sel_q == OP_DIV) begin
            done_sel = div_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sel_q       <= 2'b00;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_a_q <= cmd_a;
                        op_b_q <= cmd_b;
                        sel_q  <= cmd_op;
                        cnt_q  <= '0;
                        if (cmd_op == OP_MUL) begin
                            mul_start_q <= 1'b1;
                            state_q     <= WAIT;
                        end else if (cmd_op == OP_DIV) begin
                            // Divide-by-zero is reported without launching the divider.
                            if (cmd_b != '0) begin
                                div_start_q <= 1'b1;
                                state_q     <= WAIT;
                            end else begin
                                res_data_q <= '0;
                                res_err_q  <= 1'b1;
                                state_q    <= RESULT;
                            end
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    res_data_q <= mux_out;
                    res_err_q  <= 1'b0;
                    state_q    <= RESULT;
                end
                WAIT: begin
                    if (done_sel) begin
                        res_data_q <= mux_out;
                        res_err_q  <= 1'b0;
                        state_q    <= RESULT;
                    end else if (cnt_q == CNT_LAST) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state_q    <= RESULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == RESULT);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign sel       = sel_q;
    assign mul_start = mul_start_q;
    assign div_start = div_start_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed bench for alu_op_ctrl: table of single operations plus reset and
// backpressure sequences, all expectations hand-computed.
module tb_alu_op_ctrl;

    localparam int W = 8;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   sel;
    logic         mul_start;
    logic         div_start;
    logic         mul_done;
    logic         div_done;
    logic [W-1:0] mux_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         busy;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad = 0;

    alu_op_ctrl #(.W(W), .TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .op_a(op_a), .op_b(op_b), .sel(sel),
        .mul_start(mul_start), .div_start(div_start),
        .mul_done(mul_done), .div_done(div_done), .mux_out(mux_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] mux;
        int         done_kind;   // 0 none, 1 mul_done, 2 div_done
        int         done_cyc;    // WAIT cycle index of the pulse, 0 = start-pulse cycle
        logic [7:0] exp_data;
        logic       exp_err;
        logic       exp_ms;
        logic       exp_ds;
        int         exp_lat;     // edges after accept until res_valid is high
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(string name, logic [1:0] op, logic [7:0] a, logic [7:0] b,
                                logic [7:0] mux, int dk, int dc, logic [7:0] ed, logic ee,
                                logic ems, logic eds, int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.mux = mux;
        v.done_kind = dk; v.done_cyc = dc; v.exp_data = ed; v.exp_err = ee;
        v.exp_ms = ems; v.exp_ds = eds; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        mux_out = v.mux; res_ready = 1'b0;
        chk({v.name, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk({v.name, ".sel"}, 32'(sel), 32'(v.op));
        chk({v.name, ".op_a"}, 32'(op_a), 32'(v.a));
        chk({v.name, ".op_b"}, 32'(op_b), 32'(v.b));
        chk({v.name, ".mul_start"}, 32'(mul_start), 32'(v.exp_ms));
        chk({v.name, ".div_start"}, 32'(div_start), 32'(v.exp_ds));
        chk({v.name, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!res_valid && n < 40) begin
            mul_done = (v.done_kind == 1 && v.done_cyc == n);
            div_done = (v.done_kind == 2 && v.done_cyc == n);
            tick();
            mul_done = 1'b0;
            div_done = 1'b0;
            n++;
            if (mul_start || div_start) begin
                chk({v.name, ".start_pulse_len"}, 32'({mul_start, div_start}), 32'd0);
            end
        end
        chk({v.name, ".latency"}, 32'(n), 32'(v.exp_lat));
        chk({v.name, ".res_data"}, 32'(res_data), 32'(v.exp_data));
        chk({v.name, ".res_err"}, 32'(res_err), 32'(v.exp_err));
        chk({v.name, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({v.name, ".res_valid_drop"}, 32'(res_valid), 32'd0);
        chk({v.name, ".idle_ready"}, 32'(cmd_ready), 32'd1);
        chk({v.name, ".sel_hold"}, 32'(sel), 32'(v.op));
        tick();
    endtask

    initial begin
        logic [7:0] hold_data;
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
        mul_done = 1'b0; div_done = 1'b0; mux_out = '0; res_ready = 1'b0;

        vecs[0] = mk("add",        2'b00, 8'h25, 8'h13, 8'h38, 0, 0,  8'h38, 1'b0, 1'b0, 1'b0, 1);
        vecs[1] = mk("sub",        2'b01, 8'h50, 8'h20, 8'h30, 0, 0,  8'h30, 1'b0, 1'b0, 1'b0, 1);
        vecs[2] = mk("mul",        2'b10, 8'h07, 8'h06, 8'h2A, 1, 3,  8'h2A, 1'b0, 1'b1, 1'b0, 4);
        vecs[3] = mk("mul_wrongdn",2'b10, 8'h07, 8'h06, 8'h2A, 2, 3,  8'h00, 1'b1, 1'b1, 1'b0, TIMEOUT);
        vecs[4] = mk("div0",       2'b11, 8'h40, 8'h00, 8'h55, 0, 0,  8'h00, 1'b1, 1'b0, 1'b0, 0);
        vecs[5] = mk("div_tmo",    2'b11, 8'h40, 8'h04, 8'h10, 0, 0,  8'h00, 1'b1, 1'b0, 1'b1, TIMEOUT);
        vecs[6] = mk("div_lastcyc",2'b11, 8'h40, 8'h04, 8'h10, 2, TIMEOUT-1, 8'h10, 1'b0, 1'b0, 1'b1, TIMEOUT);
        vecs[7] = mk("mul_early",  2'b10, 8'h03, 8'h05, 8'h0F, 1, 0,  8'h0F, 1'b0, 1'b1, 1'b0, 1);
        vecs[8] = mk("div_wrongdn",2'b11, 8'h40, 8'h04, 8'h10, 1, 2,  8'h00, 1'b1, 1'b0, 1'b1, TIMEOUT);
        vecs[9] = mk("mul_late",   2'b10, 8'hFF, 8'hFF, 8'h01, 1, 14, 8'h01, 1'b0, 1'b1, 1'b0, 15);

        #12;
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of a divide wait.
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 8'h40; cmd_b = 8'h04; mux_out = 8'h10;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("midwait.busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.op_a", 32'(op_a), 32'd0);
        chk("arst.op_b", 32'(op_b), 32'd0);
        chk("arst.sel", 32'(sel), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst.outs", 32'({res_valid, res_err, res_data, mul_start, div_start}), 32'd0);
        tick();
        rst_n = 1'b1;
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        chk("arst.late_done_ignored", 32'(busy), 32'd0);
        chk("arst.ready_after", 32'(cmd_ready), 32'd1);

        // Backpressure with new commands offered while the result is pending.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h25; cmd_b = 8'h13; mux_out = 8'h38;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 10) begin
            tick();
            n++;
        end
        chk("bp.res_valid", 32'(res_valid), 32'd1);
        hold_data = 8'h38;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = ~cmd_valid;
            cmd_op = 2'($urandom_range(0, 3));
            cmd_a = 8'($urandom_range(0, 255));
            cmd_b = 8'($urandom_range(0, 255));
            mux_out = 8'($urandom_range(0, 255));
            tick();
            chk("bp.res_data", 32'(res_data), 32'(hold_data));
            chk("bp.res_err", 32'(res_err), 32'd0);
            chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp.res_valid_hold", 32'(res_valid), 32'd1);
        end
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 8'h0A; cmd_b = 8'h05; mux_out = 8'h05;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp.no_turnaround", 32'(busy), 32'd0);
        chk("bp.op_a_held", 32'(op_a), 32'h25);
        tick();
        cmd_valid = 1'b0;
        chk("bp.next_accept", 32'(busy), 32'd1);
        chk("bp.next_sel", 32'(sel), 32'd1);
        chk("bp.next_op_a", 32'(op_a), 32'h0A);
        tick();
        chk("bp.next_valid", 32'(res_valid), 32'd1);
        chk("bp.next_data", 32'(res_data), 32'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
